// File: rtl/if_fetch_unit_pkg.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_pkg
//   Shared definitions for the instruction-fetch stage: the FSM state type,
//   the default reset PC and a word-alignment helper.
// ----------------------------------------------------------------------------
package if_fetch_unit_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_HOLD  = 3'd3,
        S_FLUSH = 3'd4
    } fetch_state_t;

    // Instruction addresses are always word aligned; low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/if_fetch_unit_pc_reg.sv
// ----------------------------------------------------------------------------
// if_fetch_unit_pc_reg
//   Program-counter register for the fetch stage.
//   Priority: reset > load (redirect) > increment by 4. Arithmetic wraps
//   modulo 2^32.
// Ports
//   clk        in   clock
//   reset      in   synchronous active-high reset, loads RESET_PC
//   load       in   load load_value (redirect)
//   inc        in   advance to the next sequential word
//   load_value in   32-bit word-aligned target
//   pc         out  current PC
// ----------------------------------------------------------------------------
module if_fetch_unit_pc_reg
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        inc,
    input  logic [31:0] load_value,
    output logic [31:0] pc
);

    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + 32'd4;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
//   Instruction-fetch stage. Owns the PC, issues one word fetch at a time to
//   instruction memory and presents the instruction plus its PC+4 to the
//   IF/ID register. Accepts branch/jump redirects from ID.
//
// Handshakes
//   imem:  imem_req is a one-cycle pulse with imem_addr; memory always
//          accepts it and answers with exactly one imem_rvalid pulse at
//          least one cycle later. At most one request is outstanding.
//   IF/ID: an instruction is transferred in any cycle where
//          instr_valid_F=1 and stall=0; while stall=1 IR_F/PC4_F/valid hold.
//
// Ports
//   clk, reset         clock, synchronous active-high reset
//   stall              IF/ID hold request
//   redirect           one-cycle pulse: branch/jump taken in ID
//   redirect_pc        target PC (low two bits ignored)
//   imem_req/addr      fetch request pulse and word address
//   imem_rvalid/rdata  fetch response
//   IR_F, PC4_F        fetched instruction and its address + 4
//   instr_valid_F      IR_F/PC4_F hold an instruction not yet consumed
//   fsm_state          current FSM state, for observation only
// ----------------------------------------------------------------------------
module if_fetch_unit
    import if_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         stall,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    output logic         imem_req,
    output logic [31:0]  imem_addr,
    input  logic         imem_rvalid,
    input  logic [31:0]  imem_rdata,
    output logic [31:0]  IR_F,
    output logic [31:0]  PC4_F,
    output logic         instr_valid_F,
    output fetch_state_t fsm_state
);

    localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'd3;

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  target;
    logic         pc_load;
    logic         pc_inc;

    assign target    = word_align(redirect_pc);
    assign fsm_state = state;

    // Every state takes the redirect target into the PC. The PC only
    // advances when a live (non-squashed) response is captured.
    assign pc_load = redirect;
    assign pc_inc  = (state == S_WAIT) && imem_rvalid && !redirect;

    if_fetch_unit_pc_reg #(
        .RESET_PC(RESET_PC_ALIGNED)
    ) u_pc_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (pc_load),
        .inc       (pc_inc),
        .load_value(target),
        .pc        (pc)
    );

    // imem_req is registered: it is raised on the edge that enters S_ISSUE,
    // so it is high exactly while the FSM sits in S_ISSUE.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            imem_req      <= 1'b0;
            imem_addr     <= 32'd0;
            IR_F          <= 32'd0;
            PC4_F         <= 32'd0;
            instr_valid_F <= 1'b0;
        end else begin
            imem_req <= 1'b0;
            if (redirect) begin
                // Redirect squashes any held instruction, even under stall.
                instr_valid_F <= 1'b0;
                case (state)
                    S_ISSUE: begin
                        // The request issued this cycle is now stale.
                        state <= S_FLUSH;
                    end
                    S_WAIT, S_FLUSH: begin
                        if (imem_rvalid) begin
                            // Owed response arrives now and is discarded.
                            state     <= S_ISSUE;
                            imem_req  <= 1'b1;
                            imem_addr <= target;
                        end else begin
                            state <= S_FLUSH;
                        end
                    end
                    default: begin
                        // S_IDLE, S_HOLD: nothing outstanding.
                        state     <= S_ISSUE;
                        imem_req  <= 1'b1;
                        imem_addr <= target;
                    end
                endcase
            end else begin
                case (state)
                    S_IDLE: begin
                        state     <= S_ISSUE;
                        imem_req  <= 1'b1;
                        imem_addr <= pc;
                    end
                    S_ISSUE: begin
                        state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (imem_rvalid) begin
                            IR_F          <= imem_rdata;
                            PC4_F         <= pc + 32'd4;
                            instr_valid_F <= 1'b1;
                            state         <= S_HOLD;
                        end
                    end
                    S_HOLD: begin
                        // pc already points at the next word.
                        if (!stall) begin
                            instr_valid_F <= 1'b0;
                            state         <= S_ISSUE;
                            imem_req      <= 1'b1;
                            imem_addr     <= pc;
                        end
                    end
                    S_FLUSH: begin
                        // Drop the stale response, then fetch the target.
                        if (imem_rvalid) begin
                            state     <= S_ISSUE;
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
// ----------------------------------------------------------------------------
// tb_if_fetch_unit
//   Self-checking bench for if_fetch_unit: a table of directed vectors,
//   hand-written multi-cycle sequences, and randomized traffic against a
//   transaction-level reference model. A second instance with
//   RESET_PC=FFFF_FFFC covers PC wrap-around and mid-fetch reset.
// ----------------------------------------------------------------------------
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  // --------------------------------------------------------------------------
  // clock
  // --------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // DUT a: default reset PC
  // --------------------------------------------------------------------------
  logic         reset_a = 1'b1;
  logic         stall_a = 1'b0;
  logic         redirect_a = 1'b0;
  logic [31:0]  redirect_pc_a = 32'd0;
  logic         rvalid_a = 1'b0;
  logic [31:0]  rdata_a = 32'd0;
  logic         req_a;
  logic [31:0]  addr_a;
  logic [31:0]  ir_a;
  logic [31:0]  pc4_a;
  logic         valid_a;
  fetch_state_t state_a;

  if_fetch_unit dut_a (
    .clk          (clk),
    .reset        (reset_a),
    .stall        (stall_a),
    .redirect     (redirect_a),
    .redirect_pc  (redirect_pc_a),
    .imem_req     (req_a),
    .imem_addr    (addr_a),
    .imem_rvalid  (rvalid_a),
    .imem_rdata   (rdata_a),
    .IR_F         (ir_a),
    .PC4_F        (pc4_a),
    .instr_valid_F(valid_a),
    .fsm_state    (state_a)
  );

  // --------------------------------------------------------------------------
  // DUT b: reset PC at the top of the address space
  // --------------------------------------------------------------------------
  logic         reset_b = 1'b1;
  logic         stall_b = 1'b0;
  logic         redirect_b = 1'b0;
  logic [31:0]  redirect_pc_b = 32'd0;
  logic         rvalid_b = 1'b0;
  logic [31:0]  rdata_b = 32'd0;
  logic         req_b;
  logic [31:0]  addr_b;
  logic [31:0]  ir_b;
  logic [31:0]  pc4_b;
  logic         valid_b;
  fetch_state_t state_b;

  if_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk          (clk),
    .reset        (reset_b),
    .stall        (stall_b),
    .redirect     (redirect_b),
    .redirect_pc  (redirect_pc_b),
    .imem_req     (req_b),
    .imem_addr    (addr_b),
    .imem_rvalid  (rvalid_b),
    .imem_rdata   (rdata_b),
    .IR_F         (ir_b),
    .PC4_F        (pc4_b),
    .instr_valid_F(valid_b),
    .fsm_state    (state_b)
  );

  // --------------------------------------------------------------------------
  // scoreboard counters and compare helper
  // --------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // --------------------------------------------------------------------------
  // reference model: tracks the next fetch address, whether a response is
  // owed, whether that response is stale, and the instruction on offer.
  // --------------------------------------------------------------------------
  logic [31:0] m_pc = 32'h0000_3000;
  logic        m_req = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_ir = 32'd0;
  logic [31:0] m_pc4 = 32'd0;
  logic        m_valid = 1'b0;
  logic        m_owed = 1'b0;
  logic        m_drop = 1'b0;

  task automatic model_step(input logic r, input logic st, input logic rd,
                            input logic [31:0] tgt, input logic rv,
                            input logic [31:0] rdat);
    logic req_now;
    req_now = m_req;
    m_req   = 1'b0;
    if (r) begin
      m_pc = 32'h0000_3000; m_ir = 0; m_pc4 = 0; m_valid = 0;
      m_owed = 0; m_drop = 0;
    end else if (rd) begin
      if (req_now) begin
        m_owed = 1; m_drop = 1;
      end else if (m_owed) begin
        if (rv) begin m_owed = 0; m_drop = 0; end
        else m_drop = 1;
      end
      m_pc    = tgt & 32'hFFFF_FFFC;
      m_valid = 0;
      if (!m_owed) begin m_req = 1; m_addr = m_pc; end
    end else if (req_now) begin
      m_owed = 1; m_drop = 0;
    end else if (m_owed) begin
      if (rv) begin
        m_owed = 0;
        if (m_drop) begin
          m_drop = 0; m_req = 1; m_addr = m_pc;
        end else begin
          m_ir = rdat; m_pc4 = m_pc + 4; m_pc = m_pc + 4; m_valid = 1;
        end
      end
    end else if (m_valid) begin
      if (!st) begin m_valid = 0; m_req = 1; m_addr = m_pc; end
    end else begin
      m_req = 1; m_addr = m_pc;
    end
  endtask

  // --------------------------------------------------------------------------
  // driver tasks: inputs set away from the edge, outputs sampled #1 after it
  // --------------------------------------------------------------------------
  task automatic drive_a(input logic r, input logic st, input logic rd,
                         input logic [31:0] tgt, input logic rv,
                         input logic [31:0] rdat);
    reset_a = r; stall_a = st; redirect_a = rd; redirect_pc_a = tgt;
    rvalid_a = rv; rdata_a = rdat;
    model_step(r, st, rd, tgt, rv, rdat);
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic r, input logic rv, input logic [31:0] rdat);
    reset_b = r; rvalid_b = rv; rdata_b = rdat;
    @(posedge clk);
    #1;
  endtask

  task automatic check_a_vs_model(input string tag);
    chk({tag, " req"},   {31'd0, req_a},   {31'd0, m_req});
    chk({tag, " valid"}, {31'd0, valid_a}, {31'd0, m_valid});
    chk({tag, " ir"},    ir_a,  m_ir);
    chk({tag, " pc4"},   pc4_a, m_pc4);
    if (m_req) chk({tag, " addr"}, addr_a, m_addr);
  endtask

  // --------------------------------------------------------------------------
  // directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic        rst;
    logic        st;
    logic        rd;
    logic [31:0] tgt;
    logic        rv;
    logic [31:0] rdat;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_ir;
    logic [31:0] e_pc4;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic rst, input logic st, input logic rd,
                              input logic [31:0] tgt, input logic rv,
                              input logic [31:0] rdat, input logic e_req,
                              input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_ir, input logic [31:0] e_pc4);
    vec_t v;
    v.rst = rst; v.st = st; v.rd = rd; v.tgt = tgt; v.rv = rv; v.rdat = rdat;
    v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_ir = e_ir; v.e_pc4 = e_pc4;
    return v;
  endfunction

  localparam logic [31:0] A0 = 32'h1111_0000, A1 = 32'h1111_0001, A2 = 32'h1111_0002;
  localparam logic [31:0] B0 = 32'h2222_0000, C0 = 32'h3333_0000, D0 = 32'h4444_0000;
  localparam logic [31:0] F0 = 32'h5555_0000;

  task automatic fill_table();
    //            rst st rd tgt           rv rdat           req addr          vld ir  pc4
    // sequential fetch, latency 1
    tbl.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            0, 0,  0));
    tbl.push_back(mk(1, 0, 0, 0,            0, 0,            0, 0,            0, 0,  0));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0,            1, 32'h3000,     0, 0,  0));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            0, 0,  0));
    tbl.push_back(mk(0, 0, 0, 0,            1, A0,           0, 0,            1, A0, 32'h3004));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0,            1, 32'h3004,     0, A0, 32'h3004));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            0, A0, 32'h3004));
    tbl.push_back(mk(0, 0, 0, 0,            1, A1,           0, 0,            1, A1, 32'h3008));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0,            1, 32'h3008,     0, A1, 32'h3008));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            0, A1, 32'h3008));
    tbl.push_back(mk(0, 0, 0, 0,            1, A2,           0, 0,            1, A2, 32'h300C));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0,            1, 32'h300C,     0, A2, 32'h300C));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            0, A2, 32'h300C));
    // redirect in S_WAIT, response 3 cycles later is dropped
    tbl.push_back(mk(0, 0, 1, 32'h4003,     0, 0,            0, 0,            0, A2, 32'h300C));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            0, A2, 32'h300C));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            0, A2, 32'h300C));
    tbl.push_back(mk(0, 0, 0, 0,            1, 32'hDEAD_DEAD, 1, 32'h4000,    0, A2, 32'h300C));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            0, A2, 32'h300C));
    // redirect coincident with rvalid in S_WAIT
    tbl.push_back(mk(0, 0, 1, 32'h5000,     1, 32'hBEEF_BEEF, 1, 32'h5000,    0, A2, 32'h300C));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            0, A2, 32'h300C));
    tbl.push_back(mk(0, 0, 0, 0,            1, B0,           0, 0,            1, B0, 32'h5004));
    // redirect with stall in S_HOLD
    tbl.push_back(mk(0, 1, 1, 32'h6000,     0, 0,            1, 32'h6000,     0, B0, 32'h5004));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0,            0, 0,            0, B0, 32'h5004));
    tbl.push_back(mk(0, 0, 0, 0,            1, C0,           0, 0,            1, C0, 32'h6004));
    // redirect in S_ISSUE: issued request becomes stale
    tbl.push_back(mk(0, 0, 0, 0,            0, 0,            1, 32'h6004,     0, C0, 32'h6004));
    tbl.push_back(mk(0, 0, 1, 32'h7008,     0, 0,            0, 0,            0, C0, 32'h6004));
    tbl.push_back(mk(0, 0, 0, 0,            1, 32'h5555_5555, 1, 32'h7008,    0, C0, 32'h6004));
    // stall outside S_HOLD has no effect; spurious rvalid in S_HOLD ignored
    tbl.push_back(mk(0, 1, 0, 0,            0, 0,            0, 0,            0, C0, 32'h6004));
    tbl.push_back(mk(0, 1, 0, 0,            1, D0,           0, 0,            1, D0, 32'h700C));
    tbl.push_back(mk(0, 1, 0, 0,            1, 32'hEEEE_EEEE, 0, 0,           1, D0, 32'h700C));
    tbl.push_back(mk(0, 0, 0, 0,            0, 0,            1, 32'h700C,     0, D0, 32'h700C));
  endtask

  // --------------------------------------------------------------------------
  // main sequence
  // --------------------------------------------------------------------------
  initial begin
    int cd;
    logic r, st, rd, rv;
    logic [31:0] tgt, rdat;

    fill_table();
    #2;

    // table-driven vectors
    foreach (tbl[i]) begin
      drive_a(tbl[i].rst, tbl[i].st, tbl[i].rd, tbl[i].tgt, tbl[i].rv, tbl[i].rdat);
      chk($sformatf("vec%0d req", i),   {31'd0, req_a},   {31'd0, tbl[i].e_req});
      chk($sformatf("vec%0d valid", i), {31'd0, valid_a}, {31'd0, tbl[i].e_valid});
      chk($sformatf("vec%0d ir", i),    ir_a,  tbl[i].e_ir);
      chk($sformatf("vec%0d pc4", i),   pc4_a, tbl[i].e_pc4);
      if (tbl[i].e_req) chk($sformatf("vec%0d addr", i), addr_a, tbl[i].e_addr);
      if (i == 0) chk("reset state", {29'd0, state_a}, {29'd0, S_IDLE});
    end

    // stall for 5 cycles while holding an instruction
    drive_a(0, 0, 0, 0, 0, 0);
    chk("hold_seq wait req", {31'd0, req_a}, 32'd0);
    drive_a(0, 0, 0, 0, 1, F0);
    chk("hold_seq valid", {31'd0, valid_a}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      drive_a(0, 1, 0, 0, 0, 0);
      chk($sformatf("hold_seq stall%0d req", k),   {31'd0, req_a},   32'd0);
      chk($sformatf("hold_seq stall%0d valid", k), {31'd0, valid_a}, 32'd1);
      chk($sformatf("hold_seq stall%0d ir", k),    ir_a,  F0);
      chk($sformatf("hold_seq stall%0d pc4", k),   pc4_a, 32'h7010);
    end
    drive_a(0, 0, 0, 0, 0, 0);
    chk("hold_seq release req",   {31'd0, req_a},   32'd1);
    chk("hold_seq release addr",  addr_a, 32'h7010);
    chk("hold_seq release valid", {31'd0, valid_a}, 32'd0);

    // wrap-around and mid-fetch reset on the second instance
    drive_b(1, 0, 0);
    drive_b(1, 0, 0);
    chk("wrap reset req",   {31'd0, req_b},   32'd0);
    chk("wrap reset valid", {31'd0, valid_b}, 32'd0);
    drive_b(0, 0, 0);
    chk("wrap fetch0 req",  {31'd0, req_b}, 32'd1);
    chk("wrap fetch0 addr", addr_b, 32'hFFFF_FFFC);
    drive_b(0, 0, 0);
    drive_b(0, 1, 32'h0BAD_CAFE);
    chk("wrap pc4 valid", {31'd0, valid_b}, 32'd1);
    chk("wrap pc4 ir",    ir_b,  32'h0BAD_CAFE);
    chk("wrap pc4 zero",  pc4_b, 32'd0);
    drive_b(0, 0, 0);
    chk("wrap fetch1 req",  {31'd0, req_b}, 32'd1);
    chk("wrap fetch1 addr", addr_b, 32'd0);
    drive_b(0, 0, 0);
    drive_b(1, 1, 32'h2222_2222);
    chk("midreset req",   {31'd0, req_b},   32'd0);
    chk("midreset valid", {31'd0, valid_b}, 32'd0);
    chk("midreset ir",    ir_b,  32'd0);
    chk("midreset pc4",   pc4_b, 32'd0);
    chk("midreset state", {29'd0, state_b}, {29'd0, S_IDLE});
    drive_b(0, 0, 0);
    chk("refetch req",  {31'd0, req_b}, 32'd1);
    chk("refetch addr", addr_b, 32'hFFFF_FFFC);

    // randomized traffic against the reference model
    drive_a(1, 0, 0, 0, 0, 0);
    check_a_vs_model("rand reset");
    cd = 0;
    for (int n = 0; n < 3000; n++) begin
      rv = (cd == 1);
      if (cd > 0) cd--;
      if ($urandom_range(0, 31) == 0) rv = 1'b1;
      r    = ($urandom_range(0, 199) == 0);
      st   = ($urandom_range(0, 2) == 0);
      rd   = ($urandom_range(0, 9) == 0);
      tgt  = $urandom;
      rdat = $urandom;
      drive_a(r, st, rd, tgt, rv, rdat);
      check_a_vs_model($sformatf("rand%0d", n));
      // memory answers 1..3 cycles after the request cycle
      if (r) cd = 0;
      else if (req_a) cd = $urandom_range(2, 4);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
